seg7_count_display: RTL
=======================

// Module: seg7_count_display
// PURPOSE
//  Display stage that sits directly downstream of the 8-bit up/down counter.
//  Takes the counter's binary value q[7:0] and converts it to three BCD digits (000-255).
//  Conversion is sequential shift-add-3 (double dabble).
//  Drives a 4-digit common-anode 7-segment display by time-multiplexed scanning.
//  The display runs on the same system clock as the counter, with no extra clock domain.
// PARAMETERS
//  SCAN_DIV  100000  clk cycles each digit stays lit; legal range >= 2
//  BLANK_LZ  1       1 = blank leading zeros in hundreds/tens; 0 = always show 3 digits
// PORTS
//  clk    in   1  system clock; all state updates on the rising edge
//  reset  in   1  asynchronous, active-high; clears all state immediately
//  value  in   8  binary count from the counter stage; unsigned
//  seg    out  7  segment drive {g,f,e,d,c,b,a}, active-low, registered
//  an     out  4  digit enables, an[0] = ones digit, active-low one-hot, registered
//  bcd    out  12 {hundreds,tens,ones} of the last completed conversion
//  busy   out  1  high while a conversion is in progress
// BEHAVIOUR
//  Reset values
//   seg=7'h7F, an=4'hF, bcd=12'h000, busy=0.
//   Internal state: state=IDLE, shown=8'h00, scan divider=0, digit index=0.
//  Conversion FSM, states IDLE -> SHIFT -> LOAD -> IDLE
//   IDLE: if value != shown, capture value into the shift register, clear the BCD scratch
//    and the iteration count, then go to SHIFT. Otherwise stay in IDLE.
//   SHIFT, one edge per bit, MSB first:
//    - each BCD nibble >= 5 gets +3;
//    - then {scratch,shreg} is shifted left 1.
//    After 8 shifts go to LOAD.
//   LOAD: bcd <= scratch; shown <= captured value; go to IDLE.
//  busy = (state != IDLE).
//  Latency: a value change seen at edge N gives updated bcd at edge N+9 (1 capture + 8 shift).
//   LOAD completes at N+9, so bcd is visible after that edge. Back-to-back changes therefore
//   pace at 10 cycles per conversion.
//  value changes during SHIFT/LOAD are ignored. IDLE re-checks on the next edge and
//   converts the newest value; intermediate values may never be displayed.
//  bcd changes only in LOAD (atomic; no partial digits visible). Max result 0x255, no overflow.
//  Scan
//   Divider counts 0..SCAN_DIV-1 continuously, independent of the FSM.
//   On terminal count: divider -> 0, digit index 0->1->2->3->0, and seg/an are loaded
//    for the new index from the current bcd.
//   an pattern by index: 0:1110 1:1101 2:1011 3:0111.
//   Digit 3 is always blank (seg=7'h7F), but its anode is still pulsed.
//   Blanking with BLANK_LZ=1:
//    - hundreds blank if hundreds==0;
//    - tens blank if hundreds==0 && tens==0;
//    - ones is never blanked.
//  Segment codes, active-low:
//   0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
//  Reset mid-operation: FSM aborts and bcd returns to 000. First lit digit is index 1
//   after SCAN_DIV cycles; value is reconverted if nonzero.
// TESTING
//  1. Reset, value=0, SCAN_DIV=4
//     -> an=F and seg=7F until first terminal count.
//     -> Then an cycles 1101,1011,0111,1110, each held exactly 4 clks.
//     -> Ones digit seg=40; other digits 7F.
//  2. value 0->255 at edge N
//     -> busy high edges N..N+8.
//     -> bcd=0x255 after edge N+9.
//     -> Scan shows 2(24),5(12),5(12) on an[2],an[1],an[0].
//  3. value=7, BLANK_LZ=1
//     -> bcd=0x007; an[0] shows seg=78; an[1], an[2], an[3] show 7F.
//     -> With BLANK_LZ=0, an[2] and an[1] show 40.
//  4. value 100->101 at N+3 during conversion
//     -> bcd=0x100 at N+9.
//     -> Reconversion starts N+10; bcd=0x101 at N+19.
//  5. Reset asserted mid-SHIFT with value=200
//     -> outputs return to reset values immediately.
//     -> After release, bcd=0x200 exactly 10 edges later.
//  6. Up-count wrap 255->0 via value
//     -> bcd goes 0x255 -> 0x000.
//     -> Hundreds and tens blank on the next scan.

Source files
------------

// File: rtl/seg7_count_display.sv
// Display stage for the 8-bit counter. It converts the binary count to BCD with a
// sequential double dabble, then scans three digits onto a 4-digit common-anode display.
module seg7_count_display #(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [11:0] bcd,
  output logic       busy
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  shreg;
  logic [7:0]  captured;
  logic [7:0]  shown;
  logic [11:0] scratch;
  logic [11:0] adjusted;
  logic [2:0]  bit_cnt;

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic [1:0]       next_idx;
  logic [6:0]       scan_seg;
  logic [3:0]       scan_an;

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = 7'h7F;
    endcase
    return code;
  endfunction

  assign busy = (state != IDLE);

  always_comb begin
    adjusted = scratch;
    for (int i = 0; i < 3; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (value != shown) state_next = SHIFT;
      SHIFT:   if (bit_cnt == 3'd7) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Value changes arriving while busy are simply not captured; IDLE picks up the newest one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= 8'h00;
      captured <= 8'h00;
      shown    <= 8'h00;
      scratch  <= 12'h000;
      bit_cnt  <= 3'd0;
      bcd      <= 12'h000;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (value != shown) begin
            shreg    <= value;
            captured <= value;
            scratch  <= 12'h000;
            bit_cnt  <= 3'd0;
          end
        end
        SHIFT: begin
          {scratch, shreg} <= {adjusted, shreg} << 1;
          bit_cnt          <= bit_cnt + 3'd1;
        end
        LOAD: begin
          bcd   <= scratch;
          shown <= captured;
        end
        default: ;
      endcase
    end
  end

  assign next_idx = idx + 2'd1;

  always_comb begin
    scan_an           = 4'hF;
    scan_an[next_idx] = 1'b0;
    scan_seg          = 7'h7F;
    case (next_idx)
      2'd0: scan_seg = seg_code(bcd[3:0]);
      2'd1: begin
        if (!(BLANK_LZ && bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0)) begin
          scan_seg = seg_code(bcd[7:4]);
        end
      end
      2'd2: begin
        if (!(BLANK_LZ && bcd[11:8] == 4'd0)) begin
          scan_seg = seg_code(bcd[11:8]);
        end
      end
      default: scan_seg = 7'h7F;
    endcase
  end

  // The scan runs freely; seg/an pick up the current bcd only when the digit advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
      idx <= 2'd0;
      seg <= 7'h7F;
      an  <= 4'hF;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= next_idx;
      seg <= scan_seg;
      an  <= scan_an;
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule
